button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/blackjack_pkg.sv | 34 +++
 rtl/key_debounce.sv | 43 ++++
 rtl/button_conditioner.sv | 95 +++++++++
 tb/tb_button_conditioner.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared command encodings and event helpers for the blackjack input path and FSM.
// Combinational helpers only; no state lives here.
package blackjack_pkg;

    localparam logic [1:0] CMD_HIT   = 2'd0;
    localparam logic [1:0] CMD_STAND = 2'd1;
    localparam logic [1:0] CMD_DEAL  = 2'd2;

    typedef struct packed {
        logic deal;
        logic stand;
        logic hit;
    } cmd_ev_t;

    function automatic logic any_event(input cmd_ev_t ev);
        return ev.deal | ev.stand | ev.hit;
    endfunction

    // More than one event in the same cycle means all but the winner are lost.
    function automatic logic multi_event(input cmd_ev_t ev);
        return (ev.deal & ev.stand) | (ev.deal & ev.hit) | (ev.stand & ev.hit);
    endfunction

    function automatic logic [1:0] pick_cmd(input cmd_ev_t ev);
        if (ev.deal) begin
            return CMD_DEAL;
        end else if (ev.stand) begin
            return CMD_STAND;
        end else begin
            return CMD_HIT;
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Purpose: one push-button channel: two-flop sync, debounce counter, level and press pulse.
// Latency: level changes DEBOUNCE_CYCLES+2 edges after the pin changes; press pulses with it.
// Backpressure: none; press is a single-cycle pulse that the consumer must take or lose.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Toggling when the count would reach DEBOUNCE_CYCLES keeps the counter from ever holding it.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync <= {sync[0], ~raw_n};
            if (sync[1] == level) begin
                cnt   <= '0;
                press <= 1'b0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                cnt   <= cnt + 1'b1;
                press <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Purpose: merge debounced buttons and keyboard pulses into one prioritised command slot.
// Latency: one edge from event to cmd_valid; key presses add DEBOUNCE_CYCLES+2 for debounce.
// Backpressure: single-entry slot held until cmd_ready; events hitting a full slot are dropped.
module button_conditioner
    import blackjack_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_n,
    input  logic       ps2_hit,
    input  logic       ps2_stand,
    input  logic       ps2_deal,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    input  logic       cmd_ready,
    output logic [2:0] key_level,
    output logic       cmd_dropped
);

    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

    logic [2:0] press;
    cmd_ev_t    ev;
    logic [0:0] state;
    logic [0:0] state_nx;
    logic [1:0] code_nx;
    logic       drop_nx;
    logic       load;
    logic       accept;

    for (genvar i = 0; i < 3; i++) begin : g_ch
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw_n(key_n[i]),
            .level(key_level[i]),
            .press(press[i])
        );
    end

    assign ev.hit   = press[0] | ps2_hit;
    assign ev.stand = press[1] | ps2_stand;
    assign ev.deal  = press[2] | ps2_deal;

    // cmd_valid is the slot state itself, so cmd_ready cannot act on an empty slot.
    assign cmd_valid = (state == SLOT_FULL);
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_nx = state;
        code_nx  = cmd_code;
        drop_nx  = cmd_dropped;
        load     = 1'b0;
        case (state)
            SLOT_EMPTY: begin
                load = any_event(ev);
            end
            default: begin
                if (accept) begin
                    load = any_event(ev);
                    if (!any_event(ev)) begin
                        state_nx = SLOT_EMPTY;
                    end
                end else if (any_event(ev)) begin
                    drop_nx = 1'b1;
                end
            end
        endcase
        if (load) begin
            state_nx = SLOT_FULL;
            code_nx  = pick_cmd(ev);
            if (multi_event(ev)) begin
                drop_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SLOT_EMPTY;
            cmd_code    <= CMD_HIT;
            cmd_dropped <= 1'b0;
        end else begin
            state       <= state_nx;
            cmd_code    <= code_nx;
            cmd_dropped <= drop_nx;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4; inputs driven and outputs sampled on negedge.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key_n;
    logic       ps2_hit, ps2_stand, ps2_deal;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       cmd_ready;
    logic [2:0] key_level;
    logic       cmd_dropped;

    int n_cmp = 0;
    int n_bad = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .ps2_hit    (ps2_hit),
        .ps2_stand  (ps2_stand),
        .ps2_deal   (ps2_deal),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .key_level  (key_level),
        .cmd_dropped(cmd_dropped)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [1:0] c,
                           input logic d, input logic [2:0] l);
        chk({tag, "_valid"}, {7'd0, cmd_valid}, {7'd0, v});
        chk({tag, "_code"}, {6'd0, cmd_code}, {6'd0, c});
        chk({tag, "_dropped"}, {7'd0, cmd_dropped}, {7'd0, d});
        chk({tag, "_level"}, {5'd0, key_level}, {5'd0, l});
    endtask

    initial begin
        rst = 1'b1; key_n = 3'b111; cmd_ready = 1'b0;
        ps2_hit = 1'b0; ps2_stand = 1'b0; ps2_deal = 1'b0;
        @(negedge clk);
        tick(2);
        rst = 1'b0;
        chk_all("reset", 1'b0, 2'd0, 1'b0, 3'b000);

        // HIT key held: level at edge 6, cmd_valid at edge 7.
        key_n = 3'b110;
        tick(6);
        chk("hit_e6_valid", {7'd0, cmd_valid}, 8'd0);
        chk("hit_e6_level", {5'd0, key_level}, 8'b001);
        tick(1);
        chk_all("hit_e7", 1'b1, 2'd0, 1'b0, 3'b001);
        tick(3);
        chk_all("hit_hold", 1'b1, 2'd0, 1'b0, 3'b001);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("hit_accept_valid", {7'd0, cmd_valid}, 8'd0);
        key_n = 3'b111;
        tick(8);
        chk_all("hit_release", 1'b0, 2'd0, 1'b0, 3'b000);

        // STAND key bounce shorter than the debounce window.
        key_n = 3'b101;
        tick(3);
        key_n = 3'b111;
        tick(10);
        chk_all("bounce", 1'b0, 2'd0, 1'b0, 3'b000);

        // Simultaneous HIT and DEAL: DEAL wins, HIT dropped.
        ps2_hit = 1'b1; ps2_deal = 1'b1;
        tick(1);
        ps2_hit = 1'b0; ps2_deal = 1'b0;
        chk_all("prio", 1'b1, 2'd2, 1'b1, 3'b000);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_all("rst1", 1'b0, 2'd0, 1'b0, 3'b000);

        // Accept and reload in the same cycle: no bubble, no drop.
        ps2_stand = 1'b1;
        tick(1);
        ps2_stand = 1'b0;
        chk_all("stand_load", 1'b1, 2'd1, 1'b0, 3'b000);
        cmd_ready = 1'b1; ps2_hit = 1'b1;
        tick(1);
        cmd_ready = 1'b0; ps2_hit = 1'b0;
        chk_all("reload", 1'b1, 2'd0, 1'b0, 3'b000);
        cmd_ready = 1'b1;
        tick(1);
        chk("drain_valid", {7'd0, cmd_valid}, 8'd0);
        tick(2);
        chk("idle_ready_valid", {7'd0, cmd_valid}, 8'd0);
        // Ready asserted while empty must not consume the incoming command.
        ps2_stand = 1'b1;
        tick(1);
        ps2_stand = 1'b0; cmd_ready = 1'b0;
        chk_all("empty_ready", 1'b1, 2'd1, 1'b0, 3'b000);

        // Full slot, no accept: DEAL dropped, STAND kept.
        ps2_deal = 1'b1;
        tick(1);
        ps2_deal = 1'b0;
        chk_all("full_drop", 1'b1, 2'd1, 1'b1, 3'b000);
        tick(2);
        chk("drop_sticky", {7'd0, cmd_dropped}, 8'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_all("rst2", 1'b0, 2'd0, 1'b0, 3'b000);

        // DEAL key held across reset: exactly one DEAL at edge 7 after release of reset.
        key_n = 3'b011;
        tick(2);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk_all("deal_rst", 1'b0, 2'd0, 1'b0, 3'b000);
        tick(6);
        chk("deal_e6_valid", {7'd0, cmd_valid}, 8'd0);
        tick(1);
        chk_all("deal_e7", 1'b1, 2'd2, 1'b0, 3'b100);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("deal_accept_valid", {7'd0, cmd_valid}, 8'd0);
        tick(20);
        chk_all("deal_held", 1'b0, 2'd2, 1'b0, 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
